// File: rtl/gin_pkg.sv
// Shared types and helpers for the gin bus-to-caster transmitter.
// Holds the tag-width helper and the transmit FSM state encoding.
package gin_pkg;

    function automatic int gin_idw(input int num_col);
        return (num_col < 2) ? 1 : $clog2(num_col);
    endfunction

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } gin_tx_state_t;

endpackage

// File: rtl/gin_tx_fifo.sv
// Synchronous FIFO with extra-MSB wrap pointers and a synchronous clear.
// The head word is read straight from the storage flops, so it is valid the cycle after a write.
module gin_tx_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      wr_ptr_d;
    logic [AW:0]      rd_ptr_q;
    logic [AW:0]      rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Next-state pointers and storage; a clear wins over any write or read in the same cycle
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (wr_en && !full) begin
                mem_d[wr_ptr_q[AW-1:0]] = wr_data;
                wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (rd_en && !empty) begin
                rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
        end
    end

    // Pointer and storage registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: rtl/gin_bus_tx.sv
// Bus-to-caster transmitter: buffers (data, tag) packets and broadcasts each one to NUM_COL casters,
// retiring a packet only once every targeted caster has signalled ready.
module gin_bus_tx
    import gin_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int NUM_COL    = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_WIDTH  = 16,
    localparam int IDW       = gin_idw(NUM_COL)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   en,
    input  logic                   flush,
    input  logic                   s_valid,
    output logic                   s_ready,
    input  logic [DATA_WIDTH-1:0]  s_data,
    input  logic [IDW-1:0]         s_tag,
    input  logic                   s_bcast,
    input  logic [NUM_COL*IDW-1:0] col_id,
    input  logic [NUM_COL-1:0]     caster_ready,
    output logic                   bus_valid,
    output logic [DATA_WIDTH-1:0]  bus_data,
    output logic [IDW-1:0]         bus_tag,
    output logic [NUM_COL-1:0]     caster_en,
    output logic                   busy,
    output logic [CNT_WIDTH-1:0]   tx_count,
    output logic [CNT_WIDTH-1:0]   drop_count,
    output logic                   err_nomatch
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [IDW-1:0]        tag;
        logic                  bcast;
    } tx_word_t;

    localparam int WORD_W = $bits(tx_word_t);

    function automatic logic [NUM_COL-1:0] col_mask(
        input logic [IDW-1:0]         tag,
        input logic                   bcast,
        input logic [NUM_COL*IDW-1:0] ids
    );
        logic [NUM_COL-1:0] m;
        for (int c = 0; c < NUM_COL; c++) begin
            m[c] = bcast | (ids[c*IDW +: IDW] == tag);
        end
        return m;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    endfunction

    gin_tx_state_t         state_q;
    gin_tx_state_t         state_d;
    logic                  bus_valid_q;
    logic                  bus_valid_d;
    logic [DATA_WIDTH-1:0] bus_data_q;
    logic [DATA_WIDTH-1:0] bus_data_d;
    logic [IDW-1:0]        bus_tag_q;
    logic [IDW-1:0]        bus_tag_d;
    logic [NUM_COL-1:0]    caster_en_q;
    logic [NUM_COL-1:0]    caster_en_d;
    logic [CNT_WIDTH-1:0]  tx_count_q;
    logic [CNT_WIDTH-1:0]  tx_count_d;
    logic [CNT_WIDTH-1:0]  drop_count_q;
    logic [CNT_WIDTH-1:0]  drop_count_d;
    logic                  err_nomatch_q;
    logic                  err_nomatch_d;

    tx_word_t              wr_word_s;
    tx_word_t              head_s;
    logic [WORD_W-1:0]     head_raw_s;
    logic [NUM_COL-1:0]    head_mask_s;
    logic                  fifo_full_s;
    logic                  fifo_empty_s;
    logic                  push_s;
    logic                  done_s;
    logic                  fetch_s;

    assign s_ready   = rst_n & ~fifo_full_s;
    assign push_s    = s_valid & s_ready & ~flush;
    assign wr_word_s = '{data: s_data, tag: s_tag, bcast: s_bcast};
    assign head_s    = tx_word_t'(head_raw_s);
    // Decoded against the live col_id only when the head is loaded, so the bus is never re-decoded
    assign head_mask_s = col_mask(head_s.tag, head_s.bcast, col_id);
    assign done_s    = (state_q == SEND) && (&(caster_ready | ~caster_en_q));
    assign fetch_s   = en && !fifo_empty_s && !flush && ((state_q == IDLE) || done_s);

    gin_tx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (flush),
        .wr_en   (push_s),
        .wr_data (wr_word_s),
        .rd_en   (fetch_s),
        .rd_data (head_raw_s),
        .full    (fifo_full_s),
        .empty   (fifo_empty_s)
    );

    // FSM next state: retire on done, then chain-load the next head or fall back to IDLE
    always_comb begin
        state_d       = state_q;
        bus_valid_d   = bus_valid_q;
        bus_data_d    = bus_data_q;
        bus_tag_d     = bus_tag_q;
        caster_en_d   = caster_en_q;
        tx_count_d    = tx_count_q;
        drop_count_d  = drop_count_q;
        err_nomatch_d = 1'b0;
        if (flush) begin
            state_d     = IDLE;
            bus_valid_d = 1'b0;
            caster_en_d = '0;
        end else begin
            if (done_s) begin
                tx_count_d = sat_inc(tx_count_q);
            end else begin
                tx_count_d = tx_count_q;
            end
            if (fetch_s) begin
                if (|head_mask_s) begin
                    state_d     = SEND;
                    bus_valid_d = 1'b1;
                    bus_data_d  = head_s.data;
                    bus_tag_d   = head_s.tag;
                    caster_en_d = head_mask_s;
                end else begin
                    state_d       = IDLE;
                    bus_valid_d   = 1'b0;
                    caster_en_d   = '0;
                    err_nomatch_d = 1'b1;
                    drop_count_d  = sat_inc(drop_count_q);
                end
            end else if (done_s) begin
                state_d     = IDLE;
                bus_valid_d = 1'b0;
                caster_en_d = '0;
            end else begin
                state_d = state_q;
            end
        end
    end

    // FSM and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            bus_valid_q   <= 1'b0;
            bus_data_q    <= '0;
            bus_tag_q     <= '0;
            caster_en_q   <= '0;
            tx_count_q    <= '0;
            drop_count_q  <= '0;
            err_nomatch_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            bus_valid_q   <= bus_valid_d;
            bus_data_q    <= bus_data_d;
            bus_tag_q     <= bus_tag_d;
            caster_en_q   <= caster_en_d;
            tx_count_q    <= tx_count_d;
            drop_count_q  <= drop_count_d;
            err_nomatch_q <= err_nomatch_d;
        end
    end

    assign bus_valid   = bus_valid_q;
    assign bus_data    = bus_data_q;
    assign bus_tag     = bus_tag_q;
    assign caster_en   = caster_en_q;
    assign tx_count    = tx_count_q;
    assign drop_count  = drop_count_q;
    assign err_nomatch = err_nomatch_q;
    assign busy        = ~fifo_empty_s | bus_valid_q;

endmodule

// File: tb/tb_gin_bus_tx.sv
// Directed self-checking bench for gin_bus_tx with hand-computed expectations.
module tb_gin_bus_tx;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        flush;
    logic        s_valid;
    logic        s_ready;
    logic [15:0] s_data;
    logic [1:0]  s_tag;
    logic        s_bcast;
    logic [7:0]  col_id;
    logic [3:0]  caster_ready;
    logic        bus_valid;
    logic [15:0] bus_data;
    logic [1:0]  bus_tag;
    logic [3:0]  caster_en;
    logic        busy;
    logic [15:0] tx_count;
    logic [15:0] drop_count;
    logic        err_nomatch;

    int n_chk;
    int n_pass;

    gin_bus_tx dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .flush        (flush),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_tag        (s_tag),
        .s_bcast      (s_bcast),
        .col_id       (col_id),
        .caster_ready (caster_ready),
        .bus_valid    (bus_valid),
        .bus_data     (bus_data),
        .bus_tag      (bus_tag),
        .caster_en    (caster_en),
        .busy         (busy),
        .tx_count     (tx_count),
        .drop_count   (drop_count),
        .err_nomatch  (err_nomatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk        = 0;
        n_pass       = 0;
        rst_n        = 1'b0;
        en           = 1'b1;
        flush        = 1'b0;
        s_valid      = 1'b0;
        s_data       = 16'h0000;
        s_tag        = 2'd0;
        s_bcast      = 1'b0;
        col_id       = {2'd3, 2'd2, 2'd1, 2'd0};
        caster_ready = 4'b1011;

        #12;
        chk("rst_s_ready", {31'd0, s_ready}, 32'd0);
        chk("rst_bus_valid", {31'd0, bus_valid}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("post_rst_s_ready", {31'd0, s_ready}, 32'd1);

        // Unicast with a three-cycle stall on column 2
        s_valid = 1'b1; s_data = 16'h1234; s_tag = 2'd2;
        tick();
        s_valid = 1'b0;
        chk("uc_not_yet", {31'd0, bus_valid}, 32'd0);
        chk("uc_busy", {31'd0, busy}, 32'd1);
        tick();
        chk("uc_valid", {31'd0, bus_valid}, 32'd1);
        chk("uc_data", {16'd0, bus_data}, 32'h1234);
        chk("uc_tag", {30'd0, bus_tag}, 32'd2);
        chk("uc_en", {28'd0, caster_en}, 32'h4);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("uc_stall_valid", {31'd0, bus_valid}, 32'd1);
            chk("uc_stall_data", {16'd0, bus_data}, 32'h1234);
            chk("uc_stall_en", {28'd0, caster_en}, 32'h4);
        end
        chk("uc_stall_tx", {16'd0, tx_count}, 32'd0);
        caster_ready = 4'b1111;
        tick();
        chk("uc_retired_tx", {16'd0, tx_count}, 32'd1);
        chk("uc_retired_valid", {31'd0, bus_valid}, 32'd0);
        chk("uc_retired_en", {28'd0, caster_en}, 32'h0);

        // Broadcast stalls on the one column not ready
        caster_ready = 4'b1011;
        s_valid = 1'b1; s_data = 16'hBEEF; s_tag = 2'd0; s_bcast = 1'b1;
        tick();
        s_valid = 1'b0; s_bcast = 1'b0;
        tick();
        chk("bc_en", {28'd0, caster_en}, 32'hF);
        chk("bc_data", {16'd0, bus_data}, 32'hBEEF);
        tick();
        chk("bc_stall_valid", {31'd0, bus_valid}, 32'd1);
        chk("bc_stall_tx", {16'd0, tx_count}, 32'd1);
        caster_ready = 4'b1111;
        tick();
        chk("bc_retired_valid", {31'd0, bus_valid}, 32'd0);
        chk("bc_retired_tx", {16'd0, tx_count}, 32'd2);

        // Fill to full with loads held off, then drain back-to-back
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_valid = 1'b1; s_data = 16'h00A0 + 16'(i); s_tag = 2'd1;
            chk("full_s_ready", {31'd0, s_ready}, (i < 4) ? 32'd1 : 32'd0);
            tick();
        end
        s_valid = 1'b0;
        chk("en_low_no_bus", {31'd0, bus_valid}, 32'd0);
        chk("en_low_busy", {31'd0, busy}, 32'd1);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("b2b_valid", {31'd0, bus_valid}, 32'd1);
            chk("b2b_data", {16'd0, bus_data}, 32'h00A0 + 32'(i));
            chk("b2b_en", {28'd0, caster_en}, 32'h2);
        end
        tick();
        chk("b2b_done_valid", {31'd0, bus_valid}, 32'd0);
        chk("b2b_tx", {16'd0, tx_count}, 32'd6);
        chk("b2b_busy", {31'd0, busy}, 32'd0);

        // No column matches: drop, then a matching tag goes out normally
        col_id = 8'h00;
        s_valid = 1'b1; s_data = 16'h5555; s_tag = 2'd3;
        tick();
        s_valid = 1'b0;
        tick();
        chk("nm_err", {31'd0, err_nomatch}, 32'd1);
        chk("nm_drop", {16'd0, drop_count}, 32'd1);
        chk("nm_valid", {31'd0, bus_valid}, 32'd0);
        tick();
        chk("nm_err_pulse", {31'd0, err_nomatch}, 32'd0);
        s_valid = 1'b1; s_data = 16'h7777; s_tag = 2'd0;
        tick();
        s_valid = 1'b0;
        tick();
        chk("nm_next_valid", {31'd0, bus_valid}, 32'd1);
        chk("nm_next_en", {28'd0, caster_en}, 32'hF);
        chk("nm_next_data", {16'd0, bus_data}, 32'h7777);
        tick();
        chk("nm_next_tx", {16'd0, tx_count}, 32'd7);

        // Flush during a stalled SEND with two packets still queued
        col_id = {2'd3, 2'd2, 2'd1, 2'd0};
        caster_ready = 4'b0000;
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = 16'h0C00 + 16'(i); s_tag = 2'd3;
            tick();
        end
        s_valid = 1'b0;
        tick();
        chk("ctl_en_low_valid", {31'd0, bus_valid}, 32'd0);
        en = 1'b1;
        tick();
        chk("ctl_send_valid", {31'd0, bus_valid}, 32'd1);
        chk("ctl_send_en", {28'd0, caster_en}, 32'h8);
        flush = 1'b1;
        s_valid = 1'b1; s_data = 16'hDEAD; s_tag = 2'd3;
        tick();
        flush = 1'b0;
        s_valid = 1'b0;
        chk("fl_valid", {31'd0, bus_valid}, 32'd0);
        chk("fl_en", {28'd0, caster_en}, 32'h0);
        chk("fl_busy", {31'd0, busy}, 32'd0);
        chk("fl_tx", {16'd0, tx_count}, 32'd7);
        chk("fl_drop", {16'd0, drop_count}, 32'd1);

        // Asynchronous reset in the middle of a SEND
        s_valid = 1'b1; s_data = 16'h0F0F; s_tag = 2'd1;
        tick();
        s_valid = 1'b0;
        tick();
        chk("ar_pre_valid", {31'd0, bus_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, bus_valid}, 32'd0);
        chk("ar_en", {28'd0, caster_en}, 32'h0);
        chk("ar_tx", {16'd0, tx_count}, 32'd0);
        chk("ar_drop", {16'd0, drop_count}, 32'd0);
        chk("ar_err", {31'd0, err_nomatch}, 32'd0);
        chk("ar_s_ready", {31'd0, s_ready}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("ar_release_s_ready", {31'd0, s_ready}, 32'd1);
        chk("ar_release_busy", {31'd0, busy}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
